// File: rtl/dmem_pkg.sv
// Shared types and helpers for the memory-stage data memory.
// Provides the access FSM state enum, access-size codes and the byte-lane mask helper.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_state_e;

    // Access size codes carried on SizeM (bit 2 selects zero extension on loads)
    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    // Byte lanes touched by an access; misaligned halves/words are truncated to alignment
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit data RAM: synchronous byte-enabled write, combinational read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Commit enabled byte lanes on the rising edge
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/stage_m_dmem.sv
// Memory-stage data-memory responder with programmable wait states.
// Holds the IDLE/BUSY access FSM, wait counter and the captured load word.
// Optional feature macro: DMEM_SIZE_EN (adds SizeM port, byte/half accesses).
module stage_m_dmem
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
`ifdef DMEM_SIZE_EN
    input  logic [2:0]  SizeM,
`endif
    output logic [31:0] ReadDataM,
    output logic        StallM
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_C = 4'(WAIT);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic          req;
    logic          done;
    logic [AW-1:0] idx;
    logic [31:0]   ram_rdata;
    logic [31:0]   ld_word;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic          unused_addr;

    assign req  = MemReadM | MemWriteM;
    assign idx  = ALUResultM[2 +: AW];
    assign done = (state_q == BUSY) && (cnt_q == 4'd0);
    // Upper address bits wrap; byte offset matters only for sized accesses
    assign unused_addr = ^{ALUResultM[31:2+AW], ALUResultM[1:0]};

`ifdef DMEM_SIZE_EN
    // Extract the addressed lane and sign- or zero-extend it
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] sz,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz[1:0])
            2'b00:   r = sz[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = sz[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign st_be   = lane_mask(SizeM, ALUResultM[1:0]);
    assign ld_word = fmt_load(ram_rdata, SizeM, ALUResultM[1:0]);

    // Replicate narrow store data across the word so any lane picks it up
    always_comb begin
        st_data = WriteDataM;
        case (SizeM[1:0])
            2'b00:   st_data = {4{WriteDataM[7:0]}};
            2'b01:   st_data = {2{WriteDataM[15:0]}};
            default: st_data = WriteDataM;
        endcase
    end
`else
    assign st_be   = 4'b1111;
    assign ld_word = ram_rdata;
    assign st_data = WriteDataM;
`endif

    // Store commits only at the closing edge of the completion cycle, and only if still requested
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (done & MemWriteM),
        .be    (st_be),
        .addr  (idx),
        .wdata (st_data),
        .rdata (ram_rdata)
    );

    // Next-state: capture the word on accept, count down the wait states, return to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    rdata_d = ld_word;
                    cnt_d   = WAIT_C;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign ReadDataM = rdata_q;
    assign StallM    = rst & req & ~done;

endmodule

// File: tb/tb_stage_m_dmem.sv
// Self-checking bench for stage_m_dmem: a WAIT=2 instance and a WAIT=0 instance.
// Sized-access vectors run only when DMEM_SIZE_EN is defined.
module tb_stage_m_dmem;

    typedef struct {
        bit          chk_data;
        logic [31:0] data;
        int          stalls;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic [2:0]  SizeM;
    logic        StallM;
    logic        rd0, wr0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  size0;
    logic        stall0;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    stage_m_dmem #(.DEPTH(1024), .WAIT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
`ifdef DMEM_SIZE_EN
        .SizeM      (SizeM),
`endif
        .ReadDataM  (ReadDataM),
        .StallM     (StallM)
    );

    stage_m_dmem #(.DEPTH(1024), .WAIT(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (rd0),
        .MemWriteM  (wr0),
        .ALUResultM (addr0),
        .WriteDataM (wdata0),
`ifdef DMEM_SIZE_EN
        .SizeM      (size0),
`endif
        .ReadDataM  (rdata0),
        .StallM     (stall0)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        if (inst == 0) begin
            MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wdata; SizeM = size;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = wdata; size0 = size;
        end
    endtask

    // Called just after a rising edge; returns just after the completion cycle's closing edge
    task automatic access(input int inst, input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] size,
                          input logic [31:0] exp_data);
        exp_t        e;
        int          stalls;
        bit          done;
        logic        st;
        logic [31:0] rdv;
        e.chk_data = rd;
        e.data     = exp_data;
        e.stalls   = (inst == 0) ? 3 : 1;
        e.tag      = tag;
        sb_q.push_back(e);
        drive(inst, rd, wr, addr, wdata, size);
        stalls = 0;
        done   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            st  = (inst == 0) ? StallM : stall0;
            rdv = (inst == 0) ? ReadDataM : rdata0;
            if (st) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1;
                e = sb_q.pop_front();
                check({e.tag, "_stall"}, 32'(stalls), 32'(e.stalls));
                if (e.chk_data) check({e.tag, "_data"}, rdv, e.data);
            end
        end
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        @(posedge clk);
        #1;
        drive(inst, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        #12;
        check("rst_stall", {31'h0, StallM}, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);
        MemReadM = 1'b1;
        #1;
        check("rst_stall_req", {31'h0, StallM}, 32'h0);
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Store then back-to-back load of the same word
        access(0, "st_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0);
        access(0, "ld_10", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF);
        @(negedge clk);
        check("idle_stall", {31'h0, StallM}, 32'h0);
        check("idle_hold", ReadDataM, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // Zero-wait instance, then idle bus
        access(1, "w0_st", 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 3'b010, 32'h0);
        access(1, "w0_ld", 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w0_idle_stall", {31'h0, stall0}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Address wrap modulo DEPTH, and a second independent word
        access(0, "st_wrap", 1'b0, 1'b1, 32'd4096 + 32'h10, 32'h5A5A1234, 3'b010, 32'h0);
        access(0, "st_20", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0);
        access(0, "ld_wrap", 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h5A5A1234);
        access(0, "ld_20", 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D);

        // Reset in the middle of a store leaves the RAM word intact
        access(0, "st_30", 1'b0, 1'b1, 32'h30, 32'h11112222, 3'b010, 32'h0);
        drive(0, 1'b0, 1'b1, 32'h30, 32'h99998888, 3'b010);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_stall", {31'h0, StallM}, 32'h0);
        check("midrst_rdata", ReadDataM, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access(0, "ld_30", 1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 32'h11112222);

`ifdef DMEM_SIZE_EN
        access(0, "sw_0", 1'b0, 1'b1, 32'h0, 32'h000080FF, 3'b010, 32'h0);
        access(0, "lb_0", 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 32'hFFFFFFFF);
        access(0, "lbu_0", 1'b1, 1'b0, 32'h0, 32'h0, 3'b100, 32'h000000FF);
        access(0, "lh_0", 1'b1, 1'b0, 32'h0, 32'h0, 3'b001, 32'hFFFF80FF);
        access(0, "lb_1", 1'b1, 1'b0, 32'h1, 32'h0, 3'b000, 32'hFFFFFF80);
        access(0, "sb_3", 1'b0, 1'b1, 32'h3, 32'h00000012, 3'b000, 32'h0);
        access(0, "lw_0", 1'b1, 1'b0, 32'h0, 32'h0, 3'b010, 32'h120080FF);
        access(0, "lhu_2", 1'b1, 1'b0, 32'h2, 32'h0, 3'b101, 32'h00001200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
